tile_writeback: RTL and testbench

- Downstream neighbour of the pixel shader.
- Once the shader finishes a nanotile, this block streams that tile's 8x8 RGB565 pixels into the linear framebuffer through a ready/valid write port.
- It reads whichever double-buffer half is selected at start, leaving the shader free to rasterize into the other half.
- Pixels falling outside the screen are clipped and never written.

---
 rtl/typhoon_pkg.sv | 24 ++
 rtl/tile_addr_gen.sv | 65 ++++++
 rtl/tile_writeback.sv | 113 +++++++++++
 tb/tb_tile_writeback.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/typhoon_pkg.sv
// Shared definitions for the tile writeback path.
// Holds the tile / framebuffer geometry constants, the RGB565 pixel type and
// the flush FSM state encoding used by tile_writeback and tile_addr_gen.
package typhoon_pkg;
  localparam int nanoTileDim = 8;
  localparam int FB_WIDTH    = 640;
  localparam int FB_HEIGHT   = 480;
  localparam int ADDR_W      = 20;
  localparam int COORD_W     = $clog2(nanoTileDim);

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } flush_state_t;
endpackage

// File: rtl/tile_addr_gen.sv
// Pixel walker for one nanotile flush.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   latch             - capture offsets, compute row base, restart at [0][0]
//   advance           - step to the next pixel (row-major, x innermost)
//   offset_x/offset_y - screen position of tile pixel [0][0]
//   x, y              - current tile coordinate
//   pixel_addr        - framebuffer word address of the current pixel
//   in_bounds         - current pixel lies on screen
//   last              - current pixel is the final one of the tile
module tile_addr_gen
  import typhoon_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               latch,
  input  logic               advance,
  input  logic [9:0]         offset_x,
  input  logic [9:0]         offset_y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic               in_bounds,
  output logic               last
);
  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(nanoTileDim - 1);

  logic [9:0]        base_x;
  logic [9:0]        base_y;
  logic [ADDR_W-1:0] row_base;
  logic [10:0]       scr_x;
  logic [10:0]       scr_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_x   <= '0;
      base_y   <= '0;
      row_base <= '0;
      x        <= '0;
      y        <= '0;
    end else if (latch) begin
      base_x   <= offset_x;
      base_y   <= offset_y;
      // The only multiply; every later address is an add on top of this.
      row_base <= ADDR_W'(offset_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(offset_x);
      x        <= '0;
      y        <= '0;
    end else if (advance) begin
      if (x != MAX_C) begin
        x <= x + COORD_W'(1);
      end else if (y != MAX_C) begin
        x        <= '0;
        y        <= y + COORD_W'(1);
        row_base <= row_base + ADDR_W'(FB_WIDTH);
      end
    end
  end

  // 11-bit sums: an offset of 1023 plus 7 must not wrap back on screen.
  assign scr_x      = {1'b0, base_x} + 11'(x);
  assign scr_y      = {1'b0, base_y} + 11'(y);
  assign in_bounds  = (scr_x < 11'(FB_WIDTH)) && (scr_y < 11'(FB_HEIGHT));
  assign last       = (x == MAX_C) && (y == MAX_C);
  assign pixel_addr = row_base + ADDR_W'(x);
endmodule

// File: rtl/tile_writeback.sv
// Streams one 8x8 RGB565 nanotile from the selected double-buffer half into
// the linear framebuffer, clipping off-screen pixels.
// Ports:
//   BOARD_CLK, reset        - clock, synchronous active-high reset
//   nanoTile0/nanoTile1     - tile buffers indexed [x][y], read live
//   tileSel, tileOffsetX/Y  - buffer choice and screen offset, latched at start
//   startFlush / doneFlush  - level request / level completion (idle) flag
//   fb_addr, fb_data, fb_we - registered framebuffer write port
//   fb_ready                - sink accepts on an edge with fb_we && fb_ready
//   flush_state             - current FSM state, for observation
// Write handshake: a write transfers on each rising edge where fb_we and
// fb_ready are both high; while fb_we is high and fb_ready low, fb_addr,
// fb_data and fb_we hold steady.
module tile_writeback
  import typhoon_pkg::*;
(
  input  logic              BOARD_CLK,
  input  logic              reset,
  input  logic [15:0]       nanoTile0 [nanoTileDim][nanoTileDim],
  input  logic [15:0]       nanoTile1 [nanoTileDim][nanoTileDim],
  input  logic              tileSel,
  input  logic [9:0]        tileOffsetX,
  input  logic [9:0]        tileOffsetY,
  input  logic              startFlush,
  output logic              doneFlush,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output flush_state_t      flush_state
);
  flush_state_t       state;
  logic               sel;
  logic               latch;
  logic               advance;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [ADDR_W-1:0]  pixel_addr;
  logic               in_bounds;
  logic               last;
  rgb565_t            pixel;

  assign latch       = (state == S_IDLE) && startFlush;
  assign advance     = (state == S_ADVANCE);
  assign pixel       = sel ? nanoTile1[x][y] : nanoTile0[x][y];
  assign flush_state = state;

  tile_addr_gen u_addr_gen (
    .clk        (BOARD_CLK),
    .reset      (reset),
    .latch      (latch),
    .advance    (advance),
    .offset_x   (tileOffsetX),
    .offset_y   (tileOffsetY),
    .x          (x),
    .y          (y),
    .pixel_addr (pixel_addr),
    .in_bounds  (in_bounds),
    .last       (last)
  );

  always_ff @(posedge BOARD_CLK) begin
    if (reset) begin
      state     <= S_IDLE;
      sel       <= 1'b0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      doneFlush <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          doneFlush <= ~startFlush;
          if (startFlush) begin
            sel   <= tileSel;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (in_bounds) begin
            fb_addr <= pixel_addr;
            fb_data <= pixel;
            fb_we   <= 1'b1;
            state   <= S_WAIT;
          end else begin
            // Clipped: no write, but the pixel still takes its advance step.
            fb_we <= 1'b0;
            state <= S_ADVANCE;
          end
        end
        S_WAIT: begin
          if (fb_ready) begin
            fb_we <= 1'b0;
            state <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (last) begin
            doneFlush <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_EMIT;
          end
        end
        S_DONE: begin
          doneFlush <= 1'b1;
          if (!startFlush) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_writeback.sv
module tb_tile_writeback;
  import typhoon_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [15:0]       tile0 [nanoTileDim][nanoTileDim];
  logic [15:0]       tile1 [nanoTileDim][nanoTileDim];
  logic              tileSel;
  logic [9:0]        tileOffsetX;
  logic [9:0]        tileOffsetY;
  logic              startFlush;
  logic              doneFlush;
  logic [ADDR_W-1:0] fb_addr;
  logic [15:0]       fb_data;
  logic              fb_we;
  logic              fb_ready;
  flush_state_t      flush_state;

  tile_writeback dut (
    .BOARD_CLK   (clk),
    .reset       (reset),
    .nanoTile0   (tile0),
    .nanoTile1   (tile1),
    .tileSel     (tileSel),
    .tileOffsetX (tileOffsetX),
    .tileOffsetY (tileOffsetY),
    .startFlush  (startFlush),
    .doneFlush   (doneFlush),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .fb_ready    (fb_ready),
    .flush_state (flush_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];      // {addr, data} in required write order
  logic [19:0] wr_log[$];     // accepted addresses of the current flush
  int          wr_count = 0;
  int          n_freeze = 0;
  int          ready_mode = 0; // 0: always ready, 1: random, 2: stall from write 20 on
  logic        hold_prev = 1'b0;
  logic [35:0] held;

  // Ready driver: changes just after the active edge.
  initial begin
    fb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       fb_ready = 1'b1;
        1:       fb_ready = ($urandom_range(0, 2) != 0);
        default: fb_ready = (wr_count < 20);
      endcase
    end
  end

  // Monitor: sampled on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    logic [35:0] exp_w;
    if (hold_prev && !reset) begin
      check("hold_stable", {fb_we, fb_addr, fb_data}, {1'b1, held});
      n_freeze++;
    end
    hold_prev = !reset && fb_we && !fb_ready;
    held      = {fb_addr, fb_data};
    if (!reset && fb_we && fb_ready) begin
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("write", {fb_addr, fb_data}, exp_w);
      wr_log.push_back(fb_addr);
      wr_count++;
    end
  end

  // ---------------- reference model ----------------
  // Every on-screen pixel in row-major order (x innermost) is one write; an
  // on-screen pixel costs 3 cycles, a clipped one 2 (no wait for the sink).
  task automatic build_expected(input logic sel, input int ox, input int oy,
                                output int exp_writes, output int exp_cycles);
    exp_writes = 0;
    exp_cycles = 0;
    for (int y = 0; y < nanoTileDim; y++) begin
      for (int x = 0; x < nanoTileDim; x++) begin
        int sx = ox + x;
        int sy = oy + y;
        if (sx < FB_WIDTH && sy < FB_HEIGHT) begin
          exp_q.push_back({20'(sy * FB_WIDTH + sx), sel ? tile1[x][y] : tile0[x][y]});
          exp_writes++;
          exp_cycles += 3;
        end else begin
          exp_cycles += 2;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_random();
    for (int x = 0; x < nanoTileDim; x++)
      for (int y = 0; y < nanoTileDim; y++) begin
        tile0[x][y] = 16'($urandom);
        tile1[x][y] = 16'($urandom);
      end
  endtask

  task automatic run_flush(input logic sel, input int ox, input int oy,
                           input int mode, output int writes);
    int exp_writes, exp_cycles, c;
    build_expected(sel, ox, oy, exp_writes, exp_cycles);
    wr_count = 0;
    wr_log.delete();
    ready_mode  = mode;
    tileSel     = sel;
    tileOffsetX = 10'(ox);
    tileOffsetY = 10'(oy);
    startFlush  = 1'b1;
    @(posedge clk);
    #1;
    check("done_fall", doneFlush, 0);
    // Latched values must no longer matter.
    tileSel     = ~sel;
    tileOffsetX = 10'($urandom);
    tileOffsetY = 10'($urandom);
    c = 0;
    while (!doneFlush && c < 4000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("done_rise", doneFlush, 1);
    if (mode == 0) check("latency", c, exp_cycles);
    check("write_count", wr_count, exp_writes);
    check("queue_drained", exp_q.size(), 0);
    writes = wr_count;
  endtask

  task automatic release_flush();
    startFlush = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("idle_done", doneFlush, 1);
    check("idle_state", flush_state, S_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w, c, ex_w, ex_c;
    reset       = 1'b1;
    startFlush  = 1'b0;
    tileSel     = 1'b0;
    tileOffsetX = '0;
    tileOffsetY = '0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", fb_we, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    check("rst_done", doneFlush, 1);
    check("rst_state", flush_state, S_IDLE);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic flush with a {y,x} pattern.
    for (int x = 0; x < nanoTileDim; x++)
      for (int y = 0; y < nanoTileDim; y++)
        tile0[x][y] = {8'(y), 8'(x)};
    run_flush(1'b0, 16, 8, 0, w);
    check("first_addr", wr_log[0], 5136);
    check("ninth_addr", wr_log[8], 5776);
    check("last_addr", wr_log[63], 9623);

    // Start held after completion: stays done, no new writes.
    repeat (10) @(posedge clk);
    #1;
    check("held_done", doneFlush, 1);
    check("held_no_writes", wr_count, 64);
    check("held_state", flush_state, S_DONE);
    release_flush();

    // Buffer select.
    for (int x = 0; x < nanoTileDim; x++)
      for (int y = 0; y < nanoTileDim; y++) begin
        tile0[x][y] = 16'h0000;
        tile1[x][y] = 16'hF81F;
      end
    run_flush(1'b1, 100, 50, 0, w);
    check("sel1_writes", w, 64);
    release_flush();

    // Clipping.
    fill_random();
    run_flush(1'b0, 636, 476, 0, w);
    check("corner_writes", w, 16);
    release_flush();
    run_flush(1'b1, 640, 0, 0, w);
    check("offscreen_writes", w, 0);
    release_flush();
    run_flush(1'b0, 1023, 1023, 0, w);
    check("wrap_writes", w, 0);
    release_flush();

    // Backpressure.
    fill_random();
    run_flush(1'b1, 32, 32, 1, w);
    check("stall_seen", n_freeze > 0, 1);
    release_flush();

    // Randomized flushes.
    for (int i = 0; i < 8; i++) begin
      fill_random();
      run_flush(1'($urandom), $urandom_range(0, 700), $urandom_range(0, 530),
                $urandom_range(0, 1), w);
      release_flush();
    end

    // Reset while pixel 20 is held in WAIT.
    fill_random();
    build_expected(1'b0, 0, 0, ex_w, ex_c);
    wr_count = 0;
    wr_log.delete();
    ready_mode  = 2;
    tileSel     = 1'b0;
    tileOffsetX = '0;
    tileOffsetY = '0;
    startFlush  = 1'b1;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!(fb_we && wr_count == 20) && c < 2000);
    check("stall_at_20", {fb_we, 8'(wr_count)}, {1'b1, 8'd20});
    repeat (3) @(posedge clk);
    #1;
    reset      = 1'b1;
    startFlush = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_done", doneFlush, 1);
    check("mid_rst_state", flush_state, S_IDLE);
    reset = 1'b0;
    exp_q.delete();
    ready_mode = 0;
    @(posedge clk);
    #1;
    run_flush(1'b0, 0, 0, 0, w);
    check("restart_first", wr_log[0], 0);
    check("restart_writes", w, 64);
    release_flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
